// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: latches one instruction, checks its condition
// against the CPSR flags, then issues execute/memory/writeback strobes one state at a time.
module multicycle_control_unit #(
  parameter int DATA_W      = 32,
  parameter int IMM_W       = 10,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  input  logic [3:0]        flags,
  input  logic              mem_ack,
  output logic [1:0]        type_code,
  output logic [3:0]        op_code,
  output logic [4:0]        rd,
  output logic [4:0]        rh,
  output logic [4:0]        ro,
  output logic [DATA_W-1:0] ext_imm,
  output logic              is_immediate,
  output logic              alu_en,
  output logic              cpsr_we,
  output logic              reg_we,
  output logic              link_we,
  output logic              pc_branch,
  output logic              pc_branch_link,
  output logic              pc_inc,
  output logic              mem_req,
  output logic              mem_we,
  output logic              cond_fail,
  output logic              undef,
  output logic              mem_fault,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_SKIP, S_EXEC, S_MEM, S_DONE, S_FAULT, S_WB
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_ir;
  logic [TMO_W-1:0] r_tmo;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;
  logic             w_tmo_hit;

  // flags packed as {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return c;
      4'b0011: return !c;
      4'b0100: return n;
      4'b0101: return !n;
      4'b0110: return v;
      4'b0111: return !v;
      4'b1000: return c && !z;
      4'b1001: return !c || z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return !z && (n == v);
      4'b1101: return z || (n != v);
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  assign type_code    = r_ir[27:26];
  assign is_immediate = r_ir[25];
  assign op_code      = r_ir[23:20];
  assign rd           = r_ir[19:15];
  assign rh           = r_ir[14:10];
  assign ro           = r_ir[9:5];
  assign ext_imm      = sext_imm(r_ir[IMM_W-1:0]);
  assign retired_cnt  = r_cnt;

  // r_tmo holds the number of MEM cycles already completed
  assign w_tmo_hit = (r_tmo == TMO_W'(MEM_TIMEOUT - 1));
  assign w_retire  = (r_state == S_WB) || (r_state == S_DONE) ||
                     ((r_state == S_EXEC) && (r_ir[27:26] == 2'b11));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
      r_tmo   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_FETCH) && instr_valid) r_ir <= instr;
      r_tmo <= (r_state == S_MEM) ? r_tmo + TMO_W'(1) : '0;
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next         = r_state;
    instr_ready    = 1'b0;
    alu_en         = 1'b0;
    cpsr_we        = 1'b0;
    reg_we         = 1'b0;
    link_we        = 1'b0;
    pc_branch      = 1'b0;
    pc_branch_link = 1'b0;
    pc_inc         = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    cond_fail      = 1'b0;
    undef          = 1'b0;
    mem_fault      = 1'b0;
    case (r_state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) w_next = S_DECODE;
      end
      S_DECODE: w_next = cond_pass(r_ir[31:28], flags) ? S_EXEC : S_SKIP;
      S_SKIP: begin
        cond_fail = 1'b1;
        pc_inc    = 1'b1;
        w_next    = S_FETCH;
      end
      S_EXEC: begin
        case (r_ir[27:26])
          2'b00: begin
            alu_en  = 1'b1;
            cpsr_we = r_ir[24];
            w_next  = S_WB;
          end
          2'b01: begin
            alu_en  = 1'b1;
            cpsr_we = r_ir[24];
            w_next  = S_MEM;
          end
          2'b11: begin
            alu_en         = 1'b1;
            cpsr_we        = r_ir[24];
            link_we        = r_ir[23];
            pc_branch_link = r_ir[22];
            pc_branch      = !r_ir[22];
            w_next         = S_FETCH;
          end
          default: begin
            undef  = 1'b1;
            pc_inc = 1'b1;
            w_next = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = !r_ir[20];
        // an ack arriving on the final allowed cycle still completes the access
        if (mem_ack)        w_next = r_ir[20] ? S_WB : S_DONE;
        else if (w_tmo_hit) w_next = S_FAULT;
      end
      S_DONE: begin
        pc_inc = 1'b1;
        w_next = S_FETCH;
      end
      S_FAULT: begin
        mem_fault = 1'b1;
        w_next    = S_FETCH;
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_inc = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: cycle-by-cycle strobe traces per instruction class,
// plus a CNT_W=2 instance sharing the same stimulus for counter wrap.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst, instr_valid, mem_ack;
  logic [31:0] instr;
  logic [3:0]  flags;

  logic        instr_ready, alu_en, cpsr_we, reg_we, link_we, pc_branch, pc_branch_link;
  logic        pc_inc, mem_req, mem_we, cond_fail, undef, mem_fault, is_immediate;
  logic [1:0]  type_code;
  logic [3:0]  op_code;
  logic [4:0]  rd, rh, ro;
  logic [31:0] ext_imm;
  logic [15:0] retired_cnt;

  logic        d2_instr_ready, d2_alu_en, d2_cpsr_we, d2_reg_we, d2_link_we, d2_pc_branch;
  logic        d2_pc_branch_link, d2_pc_inc, d2_mem_req, d2_mem_we, d2_cond_fail, d2_undef;
  logic        d2_mem_fault, d2_is_immediate;
  logic [1:0]  d2_type_code;
  logic [3:0]  d2_op_code;
  logic [4:0]  d2_rd, d2_rh, d2_ro;
  logic [31:0] d2_ext_imm;
  logic [1:0]  d2_retired_cnt;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [12:0] ALU = 13'h1000, CPW = 13'h0800, RWE = 13'h0400, LNK = 13'h0200;
  localparam logic [12:0] BR  = 13'h0100, BRL = 13'h0080, INC = 13'h0040, MRQ = 13'h0020;
  localparam logic [12:0] MWE = 13'h0010, CF  = 13'h0008, UND = 13'h0004, MF  = 13'h0002;
  localparam logic [12:0] RDY = 13'h0001, NONE = 13'h0000;

  logic [12:0] strb;
  assign strb = {alu_en, cpsr_we, reg_we, link_we, pc_branch, pc_branch_link, pc_inc,
                 mem_req, mem_we, cond_fail, undef, mem_fault, instr_ready};

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .flags(flags), .mem_ack(mem_ack), .type_code(type_code), .op_code(op_code), .rd(rd),
    .rh(rh), .ro(ro), .ext_imm(ext_imm), .is_immediate(is_immediate), .alu_en(alu_en),
    .cpsr_we(cpsr_we), .reg_we(reg_we), .link_we(link_we), .pc_branch(pc_branch),
    .pc_branch_link(pc_branch_link), .pc_inc(pc_inc), .mem_req(mem_req), .mem_we(mem_we),
    .cond_fail(cond_fail), .undef(undef), .mem_fault(mem_fault), .retired_cnt(retired_cnt)
  );

  multicycle_control_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(d2_instr_ready),
    .flags(flags), .mem_ack(mem_ack), .type_code(d2_type_code), .op_code(d2_op_code), .rd(d2_rd),
    .rh(d2_rh), .ro(d2_ro), .ext_imm(d2_ext_imm), .is_immediate(d2_is_immediate),
    .alu_en(d2_alu_en), .cpsr_we(d2_cpsr_we), .reg_we(d2_reg_we), .link_we(d2_link_we),
    .pc_branch(d2_pc_branch), .pc_branch_link(d2_pc_branch_link), .pc_inc(d2_pc_inc),
    .mem_req(d2_mem_req), .mem_we(d2_mem_we), .cond_fail(d2_cond_fail), .undef(d2_undef),
    .mem_fault(d2_mem_fault), .retired_cnt(d2_retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one instruction in FETCH; returns sampled in DECODE
  task automatic issue(input logic [31:0] ins);
    chk("ready_before_issue", {31'b0, instr_ready}, 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
  endtask

  logic [3:0] cc_tab [12] = '{4'hA, 4'hB, 4'h8, 4'h9, 4'hC, 4'hD, 4'hF, 4'h6, 4'h4, 4'h3, 4'h1, 4'h5};
  logic [3:0] fl_tab [12] = '{4'h8, 4'h8, 4'h2, 4'h2, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h0, 4'h4, 4'h8};
  logic       ex_tab [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0; instr = '0; flags = '0;
    repeat (3) tick();
    chk("reset_strobes", {19'b0, strb}, {19'b0, RDY});
    chk("reset_cnt", {16'b0, retired_cnt}, 32'd0);
    chk("reset_ext_imm", ext_imm, 32'd0);
    chk("reset_rd", {27'b0, rd}, 32'd0);
    rst = 1'b0;
    tick();

    // data processing, AL, immediate, S bit
    issue(32'hE341_8405);
    chk("alu_decode", {19'b0, strb}, {19'b0, NONE});
    chk("alu_ext_imm", ext_imm, 32'h0000_0005);
    chk("alu_is_imm", {31'b0, is_immediate}, 32'd1);
    chk("alu_fields", {16'b0, type_code, op_code, rd, rh}, {16'b0, 2'd0, 4'd4, 5'd3, 5'd1});
    tick(); chk("alu_exec", {19'b0, strb}, {19'b0, ALU | CPW});
    tick(); chk("alu_wb", {19'b0, strb}, {19'b0, RWE | INC});
    tick(); chk("alu_fetch", {19'b0, strb}, {19'b0, RDY});
    chk("alu_cnt", {16'b0, retired_cnt}, 32'd1);

    // EQ with Z=0 skips, with Z=1 executes
    flags = 4'b0000;
    issue(32'h0341_8405);
    chk("skip_decode", {19'b0, strb}, {19'b0, NONE});
    tick(); chk("skip_pulse", {19'b0, strb}, {19'b0, CF | INC});
    tick(); chk("skip_fetch", {19'b0, strb}, {19'b0, RDY});
    chk("skip_cnt", {16'b0, retired_cnt}, 32'd1);
    flags = 4'b0100;
    issue(32'h0341_8405);
    tick(); chk("eq_exec", {19'b0, strb}, {19'b0, ALU | CPW});
    tick(); chk("eq_wb", {19'b0, strb}, {19'b0, RWE | INC});
    tick(); chk("eq_cnt", {16'b0, retired_cnt}, 32'd2);
    flags = 4'b0000;

    // load, ack on third MEM cycle
    issue(32'hE411_0000);
    chk("ld_rd", {27'b0, rd}, 32'd2);
    tick(); chk("ld_exec", {19'b0, strb}, {19'b0, ALU});
    tick(); chk("ld_mem1", {19'b0, strb}, {19'b0, MRQ});
    tick(); chk("ld_mem2", {19'b0, strb}, {19'b0, MRQ});
    tick(); chk("ld_mem3", {19'b0, strb}, {19'b0, MRQ});
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    chk("ld_wb", {19'b0, strb}, {19'b0, RWE | INC});
    tick(); chk("ld_fetch", {19'b0, strb}, {19'b0, RDY});
    chk("ld_cnt", {16'b0, retired_cnt}, 32'd3);

    // store, immediate ack; mem_ack while in EXEC must be ignored
    issue(32'hE401_0000);
    mem_ack = 1'b1;
    tick(); chk("st_exec", {19'b0, strb}, {19'b0, ALU});
    mem_ack = 1'b0;
    tick(); chk("st_mem1", {19'b0, strb}, {19'b0, MRQ | MWE});
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    chk("st_done", {19'b0, strb}, {19'b0, INC});
    tick(); chk("st_fetch", {19'b0, strb}, {19'b0, RDY});
    chk("st_cnt", {16'b0, retired_cnt}, 32'd4);

    // load timeout: 16 MEM cycles then fault
    issue(32'hE411_0000);
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (strb !== MRQ) chk($sformatf("tmo_mem%0d", i + 1), {19'b0, strb}, {19'b0, MRQ});
    end
    chk("tmo_mem_last", {19'b0, strb}, {19'b0, MRQ});
    tick(); chk("tmo_fault", {19'b0, strb}, {19'b0, MF});
    tick(); chk("tmo_fetch", {19'b0, strb}, {19'b0, RDY});
    chk("tmo_cnt", {16'b0, retired_cnt}, 32'd4);

    // ack on the 16th MEM cycle wins over timeout
    issue(32'hE411_0000);
    tick();
    repeat (16) tick();
    chk("ack16_mem", {19'b0, strb}, {19'b0, MRQ});
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    chk("ack16_wb", {19'b0, strb}, {19'b0, RWE | INC});
    tick(); chk("ack16_cnt", {16'b0, retired_cnt}, 32'd5);

    // branch-and-link, branch via link, undefined
    issue(32'hEC80_0000);
    tick(); chk("bl_exec", {19'b0, strb}, {19'b0, ALU | LNK | BR});
    tick(); chk("bl_fetch", {19'b0, strb}, {19'b0, RDY});
    chk("bl_cnt", {16'b0, retired_cnt}, 32'd6);
    issue(32'hEC40_0000);
    tick(); chk("blr_exec", {19'b0, strb}, {19'b0, ALU | BRL});
    tick(); chk("blr_cnt", {16'b0, retired_cnt}, 32'd7);
    issue(32'hE800_0000);
    tick(); chk("und_exec", {19'b0, strb}, {19'b0, UND | INC});
    tick(); chk("und_fetch", {19'b0, strb}, {19'b0, RDY});
    chk("und_cnt", {16'b0, retired_cnt}, 32'd7);

    // negative immediate sign-extends
    issue(32'hE200_03FF);
    chk("neg_imm", ext_imm, 32'hFFFF_FFFF);
    tick(); tick(); tick();
    chk("neg_cnt", {16'b0, retired_cnt}, 32'd8);

    // reset in the middle of a memory access
    issue(32'hE411_0000);
    tick(); tick();
    chk("rst_mem", {19'b0, strb}, {19'b0, MRQ});
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rst_abort", {19'b0, strb}, {19'b0, RDY});
    chk("rst_cnt", {16'b0, retired_cnt}, 32'd0);
    chk("rst_cnt2", {30'b0, d2_retired_cnt}, 32'd0);

    // 2-bit counter wraps after four retirements
    for (int i = 1; i <= 4; i++) begin
      issue(32'hE341_8405);
      tick(); tick(); tick();
      chk($sformatf("wrap_cnt2_%0d", i), {30'b0, d2_retired_cnt}, i % 4);
    end
    chk("wrap_cnt16", {16'b0, retired_cnt}, 32'd4);

    // condition code table using a plain branch
    for (int i = 0; i < 12; i++) begin
      flags = fl_tab[i];
      issue({cc_tab[i], 28'hC00_0000});
      tick();
      chk($sformatf("cond_%0h_flags_%0h", cc_tab[i], fl_tab[i]), {19'b0, strb},
          {19'b0, ex_tab[i] ? (ALU | BR) : (CF | INC)});
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequential, parametrised successor to the combinational instruction decoder.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and latches it into an internal instruction register (IR).
- Evaluates the condition field against the CPSR flags, then sequences execute/memory/writeback as single-cycle strobes to the register bank, ALU, CPSR, data memory and PC.
- Adds a data-memory handshake with timeout and a retired-instruction counter.

Parameters:
- DATA_W, 32: width of extended immediate.
- IMM_W, 10: immediate field width, taken from instr[IMM_W-1:0]; legal range 5..10.
- MEM_TIMEOUT, 16: maximum MEM-state cycles without mem_ack before fault; must be ≥1.
- CNT_W, 16: retired counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction available.
- instr  in  32  instruction word.
- instr_ready  out  1  high only in FETCH.
- flags  in  4  CPSR {N,Z,C,V}.
- mem_ack  in  1  data memory completion.
- type_code  out  2  IR[27:26].
- op_code  out  4  IR[23:20].
- rd  out  5  IR[19:15].
- rh  out  5  IR[14:10].
- ro  out  5  IR[9:5].
- ext_imm  out  DATA_W  sign-extended IR[IMM_W-1:0].
- is_immediate  out  1  IR[25].
- alu_en  out  1  ALU strobe.
- cpsr_we  out  1  CPSR update strobe.
- reg_we  out  1  register writeback strobe.
- link_we  out  1  link register write strobe.
- pc_branch  out  1  PC load from branch target.
- pc_branch_link  out  1  PC load from link register.
- pc_inc  out  1  sequential PC advance.
- mem_req  out  1  memory access request.
- mem_we  out  1  store (valid with mem_req).
- cond_fail  out  1  instruction skipped.
- undef  out  1  undefined type.
- mem_fault  out  1  memory timeout.
- retired_cnt  out  CNT_W  executed-instruction count.

Behaviour:
- Reset (sync, rst=1 at edge):
  - State goes to FETCH; IR, retired_cnt and timeout counter clear to 0.
  - All strobes, mem_req, mem_we, cond_fail, undef and mem_fault are 0.
  - Decoded field outputs reflect IR=0.
  - Reset mid-operation aborts immediately (mem_req drops next cycle) with no completion pulses.
- State-derived outputs: all strobes, instr_ready and mem_req are Moore outputs of state + IR only; no combinational path from inputs to outputs. Field outputs are stable from DECODE until the next instruction is accepted.
- FETCH: instr_ready=1. On instr_valid=1, IR<=instr and go to DECODE; otherwise stay.
- DECODE (1 cycle): condition is evaluated from IR[31:28] and flags sampled this cycle.
  - Condition codes: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 never.
  - Condition false: cond_fail=1 and pc_inc=1 in the next state, SKIP (1 cycle), then FETCH.
  - Condition true: go to EXEC.
- EXEC (1 cycle): alu_en=1, cpsr_we=IR[24]. By type:
  - 00 data processing: go to WB.
  - 01 memory: go to MEM.
  - 11 branch: link_we=IR[23]; pc_branch_link=IR[22]; pc_branch=!IR[22]; retired_cnt+1; go to FETCH.
  - 10 undefined: undef=1, alu_en=0, cpsr_we=0, pc_inc=1; counter unchanged; go to FETCH.
- MEM: mem_req=1 and mem_we=!IR[20] held every cycle in MEM; the timeout counter increments each cycle.
  - mem_ack=1: load (IR[20]=1) goes to WB; store gets pc_inc=1 and retired_cnt+1 in the next cycle (state DONE, then FETCH).
  - Counter reaches MEM_TIMEOUT without ack: mem_fault=1 in the next cycle (FAULT state), no writeback, no count, then FETCH.
  - mem_ack in the same cycle as timeout: ack wins.
- WB (1 cycle): reg_we=1, pc_inc=1, retired_cnt+1; then FETCH.
- Inputs outside their state are ignored: mem_ack outside MEM, instr_valid outside FETCH.
- retired_cnt wraps modulo 2^CNT_W.
- Latency, accept edge to FETCH return:
  - Data-processing: 3 cycles (DECODE, EXEC, WB).
  - Branch: 2 cycles.
  - Skip: 2 cycles.
  - Store: 3+k cycles, where k = MEM cycles.
  - Load: 3+k cycles.

Test Plan:
- ALU op: flags=0, instr=0xE3418405 (AL, imm, S, op 4, rd=3, rh=1, imm=5) → ext_imm=0x00000005, is_immediate=1; alu_en+cpsr_we pulse 2 cycles after accept; reg_we+pc_inc next cycle; retired_cnt=1.
- Condition skip: flags Z=0, instr=0x03418405 (EQ) → no alu_en/reg_we; cond_fail+pc_inc single pulse; counter unchanged. Repeat with Z=1 → executes.
- Load: 0xE4110000, mem_ack asserted after 3 MEM cycles → mem_req high exactly 3 cycles with mem_we=0; reg_we then pc_inc; rd=2. Store variant 0xE4010000 → mem_we=1, no reg_we.
- Timeout: load with mem_ack held low → mem_req high 16 cycles, then mem_fault pulse, FETCH; counter unchanged. Ack on the 16th cycle → no fault.
- Branch-and-link 0xEC800000 → link_we+pc_branch pulse in EXEC, no pc_inc. 0xEC400000 → pc_branch_link=1. Undefined 0xE8000000 → undef pulse, no alu_en.
- Edge cases:
  - Immediate 0x3FF → ext_imm=0xFFFFFFFF.
  - rst asserted during MEM → mem_req low next cycle, state FETCH, counter 0.
  - CNT_W=2: after 4 retirements → 0.
